// File: rtl/mul_share_arbiter_if.sv
//==============================================================================
// Module   : mul_share_arbiter_if
// Brief    : Requester, multiplier and response bundle of the shared multiplier.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface mul_share_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_y;
  logic [31:0]         mul_x;
  logic [31:0]         mul_y;
  logic [63:0]         mul_out;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [63:0]         rsp_data;
  logic                busy;

  // slave: the arbiter itself; master: requesters plus the multiplier instance
  modport slave (
    input  req_valid, req_x, req_y, mul_out,
    output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_x, req_y, mul_out,
    input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
//==============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin sharing of one pipelined multiplier with credit limits.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 4,
  parameter int MAX_OUT = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mul_share_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUT);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_count [N_REQ];
  logic [MUL_LAT-1:0] r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [MUL_LAT];
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [63:0]        r_rsp_data;

  logic [N_REQ-1:0]   w_eligible;
  logic [N_REQ-1:0]   w_inc;
  logic [N_REQ-1:0]   w_dec;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_ret_vld;
  logic [ID_W-1:0]    w_ret_id;
  int                 w_idx;

  assign w_ret_vld = r_tag_vld[MUL_LAT-1];
  assign w_ret_id  = r_tag_id[MUL_LAT-1];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign w_eligible[i] = bus.req_valid[i] && (r_count[i] < C_MAX_OUT);
      assign w_inc[i]      = w_grant_vld && (w_grant_id == ID_W'(i));
      assign w_dec[i]      = w_ret_vld && (w_ret_id == ID_W'(i));

      // Accept and return in the same cycle cancel out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_count[i] <= '0;
        end else begin
          r_count[i] <= r_count[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
        end
      end
    end
  endgenerate

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_grant_vld && w_eligible[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(w_idx);
      end
    end
    if (rst) begin
      w_grant_vld = 1'b0;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_x     = '0;
    bus.mul_y     = '0;
    if (w_grant_vld) begin
      bus.req_ready[w_grant_id] = 1'b1;
      bus.mul_x = bus.req_x[32*int'(w_grant_id) +: 32];
      bus.mul_y = bus.req_y[32*int'(w_grant_id) +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= ID_W'((int'(w_grant_id) + 1) % N_REQ);
    end
  end

  // Tag pipe mirrors the multiplier latency so the last stage lines up with mul_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant_vld;
      r_tag_id[0]  <= w_grant_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_ret_vld;
      if (w_ret_vld) begin
        r_rsp_id   <= w_ret_id;
        r_rsp_data <= bus.mul_out;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = |r_tag_vld;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
//==============================================================================
// Module   : tb_mul_share_arbiter
// Brief    : Directed checks of mul_share_arbiter with a 4-cycle multiplier model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mul_share_arbiter;
  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 4;
  localparam int MAX_OUT = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mul_share_arbiter_if #(.N_REQ(N_REQ)) bus ();

  mul_share_arbiter #(
    .N_REQ  (N_REQ),
    .MUL_LAT(MUL_LAT),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product appears MUL_LAT cycles after the operands; never reset.
  logic [63:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= {32'b0, bus.mul_x} * {32'b0, bus.mul_y};
    for (int s = 1; s < MUL_LAT; s++) begin
      mp[s] <= mp[s-1];
    end
  end
  assign bus.mul_out = mp[MUL_LAT-1];

  typedef struct {
    logic [3:0]   v;
    logic [127:0] x;
    logic [127:0] y;
    logic [3:0]   rdy;
    logic         rv;
    logic [1:0]   id;
    logic [63:0]  d;
    logic         bz;
  } vec_t;

  vec_t tv[$];

  function automatic logic [127:0] pk(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_valid = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  logic [127:0] x2, y2, z;
  int out0, out2;
  logic [3:0] exp_rdy;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_x = '0;
    bus.req_y = '0;
    next();
    @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'h0);
    chk("reset_rsp_data", bus.rsp_data, 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    reset_dut();

    // Four-way contention, then a single op, then the product extremes.
    x2 = pk(48, 91, 1111, 111);
    y2 = pk(2, 72, 1111, 111);
    z  = '0;
    tv.push_back('{4'b1111, x2, y2, 4'b0001, 1'b0, 2'd0, 64'd0, 1'b0});
    tv.push_back('{4'b1110, x2, y2, 4'b0010, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b1100, x2, y2, 4'b0100, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b1000, x2, y2, 4'b1000, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b0000, x2, y2, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b0000, x2, y2, 4'b0000, 1'b1, 2'd0, 64'd12321, 1'b1});
    tv.push_back('{4'b0000, x2, y2, 4'b0000, 1'b1, 2'd1, 64'd1234321, 1'b1});
    tv.push_back('{4'b0000, x2, y2, 4'b0000, 1'b1, 2'd2, 64'd6552, 1'b1});
    tv.push_back('{4'b0000, x2, y2, 4'b0000, 1'b1, 2'd3, 64'd96, 1'b0});
    tv.push_back('{4'b0001, pk(0, 0, 0, 11), pk(0, 0, 0, 11), 4'b0001, 1'b0, 2'd0, 64'd0, 1'b0});
    for (int k = 0; k < 4; k++)
      tv.push_back('{4'b0000, z, z, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b0000, z, z, 4'b0000, 1'b1, 2'd0, 64'd121, 1'b0});
    tv.push_back('{4'b0001, pk(0, 0, 0, 32'hFFFFFFFF), pk(0, 0, 0, 32'hFFFFFFFF),
                   4'b0001, 1'b0, 2'd0, 64'd0, 1'b0});
    tv.push_back('{4'b0010, pk(0, 0, 0, 0), pk(0, 0, 12, 0), 4'b0010, 1'b0, 2'd0, 64'd0, 1'b1});
    for (int k = 0; k < 3; k++)
      tv.push_back('{4'b0000, z, z, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1});
    tv.push_back('{4'b0000, z, z, 4'b0000, 1'b1, 2'd0, 64'hFFFFFFFE00000001, 1'b1});
    tv.push_back('{4'b0000, z, z, 4'b0000, 1'b1, 2'd1, 64'd0, 1'b0});

    foreach (tv[i]) begin
      bus.req_valid = tv[i].v;
      bus.req_x     = tv[i].x;
      bus.req_y     = tv[i].y;
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i), 64'(bus.req_ready), 64'(tv[i].rdy));
      chk($sformatf("tv%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(tv[i].rv));
      if (tv[i].rv) begin
        chk($sformatf("tv%0d_rsp_id", i), 64'(bus.rsp_id), 64'(tv[i].id));
        chk($sformatf("tv%0d_rsp_data", i), bus.rsp_data, tv[i].d);
      end
      chk($sformatf("tv%0d_busy", i), 64'(bus.busy), 64'(tv[i].bz));
      next();
    end

    // Credit limit: one requester held valid stalls after MAX_OUT accepts.
    reset_dut();
    bus.req_valid = 4'b0001;
    bus.req_x = pk(0, 0, 0, 1);
    bus.req_y = pk(0, 0, 0, 22);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("credit%0d_ready", k), 64'(bus.req_ready[0]), 64'((k % 5) < 2));
      chk($sformatf("credit%0d_rsp_valid", k), 64'(bus.rsp_valid),
          64'(k >= 5 && (k % 5) < 2));
      if (k >= 5 && (k % 5) < 2) begin
        chk($sformatf("credit%0d_rsp_data", k), bus.rsp_data, 64'd22);
        chk($sformatf("credit%0d_rsp_id", k), 64'(bus.rsp_id), 64'd0);
      end
      next();
    end

    // Two continuous requesters: grants 0,2,0,2 then a credit stall, repeating.
    reset_dut();
    bus.req_valid = 4'b0101;
    bus.req_x = pk(0, 7, 0, 3);
    bus.req_y = pk(0, 9, 0, 5);
    out0 = 0;
    out2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      case (k % 5)
        0, 2:    exp_rdy = 4'b0001;
        1, 3:    exp_rdy = 4'b0100;
        default: exp_rdy = 4'b0000;
      endcase
      chk($sformatf("rr%0d_ready", k), 64'(bus.req_ready), 64'(exp_rdy));
      if (bus.rsp_valid) begin
        if (bus.rsp_id == 2'd0) begin
          out0--;
          chk($sformatf("rr%0d_data0", k), bus.rsp_data, 64'd15);
        end else begin
          out2--;
          chk($sformatf("rr%0d_data2", k), bus.rsp_data, 64'd63);
          chk($sformatf("rr%0d_id", k), 64'(bus.rsp_id), 64'd2);
        end
      end
      if (bus.req_ready[0]) out0++;
      if (bus.req_ready[2]) out2++;
      chk($sformatf("rr%0d_bound", k), 64'(out0 <= MAX_OUT && out2 <= MAX_OUT), 64'd1);
      next();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) next();

    // Reset with two ops in flight: they must vanish and credits must be restored.
    reset_dut();
    bus.req_valid = 4'b0001;
    bus.req_x = pk(0, 0, 0, 5);
    bus.req_y = pk(0, 0, 0, 6);
    @(negedge clk);
    chk("mid_acc0", 64'(bus.req_ready), 64'b0001);
    next();
    bus.req_x = pk(0, 0, 0, 7);
    bus.req_y = pk(0, 0, 0, 8);
    @(negedge clk);
    chk("mid_acc1", 64'(bus.req_ready), 64'b0001);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'b0000);
    next();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("mid_stale%0d", k), 64'(bus.rsp_valid), 64'd0);
      next();
    end
    bus.req_valid = 4'b0001;
    bus.req_x = pk(0, 0, 0, 13);
    bus.req_y = pk(0, 0, 0, 17);
    @(negedge clk);
    chk("post_acc0", 64'(bus.req_ready), 64'b0001);
    next();
    bus.req_x = pk(0, 0, 0, 2);
    bus.req_y = pk(0, 0, 0, 3);
    @(negedge clk);
    chk("post_acc1", 64'(bus.req_ready), 64'b0001);
    next();
    bus.req_valid = '0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'(k >= 5));
      if (k == 5) chk("post5_data", bus.rsp_data, 64'd221);
      if (k == 6) chk("post6_data", bus.rsp_data, 64'd6);
      if (k >= 5) chk($sformatf("post%0d_id", k), 64'(bus.rsp_id), 64'd0);
      next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
